// File: rtl/downsample_pkg.sv
// Shared constants and types for the 2x2 average-pool downsampler.
package downsample_pkg;

  localparam int LENGTH = 16;
  localparam int ADDR_W = 14;
  localparam int ACC_W  = LENGTH + 2;

  localparam logic [2:0] SIZE_8   = 3'd0;
  localparam logic [2:0] SIZE_16  = 3'd1;
  localparam logic [2:0] SIZE_32  = 3'd2;
  localparam logic [2:0] SIZE_64  = 3'd3;
  localparam logic [2:0] SIZE_128 = 3'd4;
  localparam logic [2:0] SIZE_MAX = SIZE_128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > SIZE_MAX) ? SIZE_MAX : size;
  endfunction

  // Output-map width minus one, i.e. the last row/column index of the result.
  function automatic logic [5:0] half_width_m1(input logic [2:0] size);
    logic [5:0] res;
    case (clamp_size(size))
      SIZE_8:   res = 6'd3;
      SIZE_16:  res = 6'd7;
      SIZE_32:  res = 6'd15;
      SIZE_64:  res = 6'd31;
      SIZE_128: res = 6'd63;
      default:  res = 6'd63;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/addr_gen_downsample.sv
// Tap/column/row counters for the downsampler: emits the registered input
// read address plus the tap index, output pixel index and last-tap flag.
module addr_gen_downsample
  import downsample_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] addr_input,
  output logic [1:0]        tap,
  output logic [ADDR_W-1:0] pix,
  output logic              last
);

  logic [1:0]        tap_q;
  logic [5:0]        col_q;
  logic [5:0]        row_q;
  logic [ADDR_W-1:0] pix_q;
  logic [5:0]        half_m1;
  logic              col_end;
  logic              row_end;
  logic [6:0]        in_row;
  logic [6:0]        in_col;
  logic [3:0]        row_shift;
  logic [ADDR_W-1:0] tap_addr;

  assign half_m1   = half_width_m1(size);
  assign col_end   = (col_q == half_m1);
  assign row_end   = (row_q == half_m1);
  assign in_row    = {row_q, tap_q[1]};
  assign in_col    = {col_q, tap_q[0]};
  assign row_shift = 4'd3 + {1'b0, size};
  // W is a power of two, so row*W is a shift by log2(W) = 3+size.
  assign tap_addr  = (ADDR_W'(in_row) << row_shift) | ADDR_W'(in_col);

  assign tap  = tap_q;
  assign pix  = pix_q;
  assign last = (tap_q == 2'd3) && col_end && row_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tap_q      <= 2'd0;
      col_q      <= 6'd0;
      row_q      <= 6'd0;
      pix_q      <= '0;
      addr_input <= '0;
    end else if (clear) begin
      tap_q <= 2'd0;
      col_q <= 6'd0;
      row_q <= 6'd0;
      pix_q <= '0;
    end else if (advance) begin
      addr_input <= tap_addr;
      tap_q      <= tap_q + 2'd1;
      if (tap_q == 2'd3) begin
        pix_q <= pix_q + ADDR_W'(1);
        if (col_end) begin
          col_q <= 6'd0;
          row_q <= row_end ? 6'd0 : row_q + 6'd1;
        end else begin
          col_q <= col_q + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/top_downsample.sv
// 2x2 average-pool downsampler: FSM, tap pipeline, accumulator and output regs.
// Build option DOWNSAMPLE_ROUND_EN selects round-half-up instead of floor.
//
// state | meaning
// IDLE  | waiting for start, size latched on accept
// RUN   | one tap read issued per cycle, row-major output pixels
// DRAIN | two cycles letting the last pixel's taps reach the output
// DONE  | single cycle, done pulses on the following cycle
module top_downsample
  import downsample_pkg::*;
#(
  parameter int length = LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        size_downsample,
  output logic              done,
  output logic [ADDR_W-1:0] addr_input,
  input  logic [length-1:0] t_data_in,
  output logic [length-1:0] t_data_out,
  output logic [ADDR_W-1:0] addr_output,
  output logic              en_write_out
);

  // Two guard bits above the sample width hold a sum of four taps.
  localparam int acc_w = ACC_W - LENGTH + length;

  state_t                  state_q;
  state_t                  state_d;
  logic [2:0]              size_q;
  logic                    drain_q;
  logic                    clear;
  logic                    issue;
  logic [1:0]              gen_tap;
  logic [ADDR_W-1:0]       gen_pix;
  logic                    gen_last;
  logic                    s1_valid;
  logic                    s2_valid;
  logic [1:0]              s1_tap;
  logic [1:0]              s2_tap;
  logic [ADDR_W-1:0]       s1_pix;
  logic [ADDR_W-1:0]       s2_pix;
  logic signed [acc_w-1:0] acc_q;
  logic signed [acc_w-1:0] tap_ext;
  logic signed [acc_w-1:0] sum;
  logic signed [acc_w-1:0] rounded;

  assign clear = (state_q == IDLE) && start;
  assign issue = (state_q == RUN);

  addr_gen_downsample u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .advance    (issue),
    .size       (size_q),
    .addr_input (addr_input),
    .tap        (gen_tap),
    .pix        (gen_pix),
    .last       (gen_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (gen_last) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      size_q  <= SIZE_8;
      drain_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) size_q <= clamp_size(size_downsample);
      drain_q <= (state_q == DRAIN) && !drain_q;
      done    <= (state_q == DONE);
    end
  end

  assign tap_ext = acc_w'(signed'(t_data_in));
  assign sum     = acc_q + tap_ext;
`ifdef DOWNSAMPLE_ROUND_EN
  assign rounded = sum + acc_w'(2);
`else
  assign rounded = sum;
`endif

  // Stage 1 lines up with addr_input, stage 2 with the returned read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_tap       <= 2'd0;
      s1_pix       <= '0;
      s2_valid     <= 1'b0;
      s2_tap       <= 2'd0;
      s2_pix       <= '0;
      acc_q        <= '0;
      t_data_out   <= '0;
      addr_output  <= '0;
      en_write_out <= 1'b0;
    end else begin
      s1_valid     <= issue;
      s1_tap       <= gen_tap;
      s1_pix       <= gen_pix;
      s2_valid     <= s1_valid;
      s2_tap       <= s1_tap;
      s2_pix       <= s1_pix;
      en_write_out <= 1'b0;
      if (s2_valid) begin
        case (s2_tap)
          2'd0: acc_q <= tap_ext;
          2'd3: begin
            t_data_out   <= rounded[length+1:2];
            addr_output  <= s2_pix;
            en_write_out <= 1'b1;
          end
          default: acc_q <= sum;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_top_downsample.sv
// Directed bench for top_downsample: vector table of 2x2 windows plus
// sequences for timing, reset abort, start hold and maximum size.
module tb_top_downsample;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  size_downsample = 3'd0;
  logic        done;
  logic [13:0] addr_input;
  logic [15:0] t_data_in = 16'h0000;
  logic [15:0] t_data_out;
  logic [13:0] addr_output;
  logic        en_write_out;

  top_downsample dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .size_downsample (size_downsample),
    .done            (done),
    .addr_input      (addr_input),
    .t_data_in       (t_data_in),
    .t_data_out      (t_data_out),
    .addr_output     (addr_output),
    .en_write_out    (en_write_out)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  always @(posedge clk) t_data_in <= mem[addr_input];

  int checks = 0;
  int errors = 0;

  int wr_cyc[$];
  int wr_addr[$];
  int wr_data[$];
  int done_cyc[$];
  int addr_log[0:127];
  int max_addr;

  typedef struct {
    logic [15:0] t0;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [15:0] t3;
    logic [15:0] exp_floor;
    logic [15:0] exp_round;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic launch(input logic [2:0] s);
    @(negedge clk);
    size_downsample = s;
    start = 1'b1;
  endtask

  // Cycle n of the run is observed at the negedge following edge n.
  task automatic collect(input int ncyc, input bit hold, input int rst_at, input int tog_at);
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cyc.delete();
    max_addr = 0;
    for (int i = 0; i < 128; i++) addr_log[i] = -1;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (en_write_out) begin
        wr_cyc.push_back(n);
        wr_addr.push_back(int'(addr_output));
        wr_data.push_back(int'(t_data_out));
      end
      if (done) done_cyc.push_back(n);
      if (n < 128) addr_log[n] = int'(addr_input);
      if (int'(addr_input) > max_addr) max_addr = int'(addr_input);
      if (n == tog_at) size_downsample = 3'd1;
      if (n == rst_at - 1) rst = 1'b0;
      if (n == rst_at) begin
        check("abort_done", int'(done), 0);
        check("abort_en_write_out", int'(en_write_out), 0);
        check("abort_addr_input", int'(addr_input), 0);
        check("abort_addr_output", int'(addr_output), 0);
        check("abort_t_data_out", int'(t_data_out), 0);
        rst = 1'b1;
      end
    end
  endtask

  task automatic check_flat_run(input string tag);
    check({tag, "_write_count"}, wr_cyc.size(), 16);
    for (int j = 0; j < 16 && j < wr_cyc.size(); j++) begin
      check($sformatf("%s_wr%0d_cycle", tag, j), wr_cyc[j], 4 * j + 6);
      check($sformatf("%s_wr%0d_addr", tag, j), wr_addr[j], j);
      check($sformatf("%s_wr%0d_data", tag, j), wr_data[j], 'h0100);
    end
    check({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cycle"}, done_cyc[0], 67);
  endtask

  task automatic check_max_run(input string tag);
    check({tag, "_write_count"}, wr_cyc.size(), 4096);
    if (wr_cyc.size() > 0) begin
      check({tag, "_last_wr_addr"}, wr_addr[wr_addr.size()-1], 4095);
      check({tag, "_last_wr_cycle"}, wr_cyc[wr_cyc.size()-1], 16386);
      check({tag, "_last_wr_data"}, wr_data[wr_data.size()-1], 'h0100);
    end
    check({tag, "_max_addr_input"}, max_addr, 16383);
    check({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cycle"}, done_cyc[0], 16387);
  endtask

  initial begin
    int base;
    int expv;

    vecs[0]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    vecs[1]  = '{16'h0000, 16'h0001, 16'h0008, 16'h0009, 16'h0004, 16'h0005};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFF};
    vecs[3]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[4]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[5]  = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001};
    vecs[6]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[9]  = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h000A, 16'h000A};
    vecs[10] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    vecs[11] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h048D, 16'h048D};
    vecs[12] = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC};
    vecs[13] = '{16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    vecs[14] = '{16'h0006, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0002};
    vecs[15] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hE000, 16'hE000};

    for (int i = 0; i < 16384; i++) mem[i] = 16'h0100;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_en_write_out", int'(en_write_out), 0);
    check("reset_addr_input", int'(addr_input), 0);
    check("reset_addr_output", int'(addr_output), 0);
    check("reset_t_data_out", int'(t_data_out), 0);
    rst = 1'b1;

    // Flat 0x0100 map, size 0
    launch(3'd0);
    collect(70, 1'b0, -1, -1);
    check_flat_run("flat");

    // Reset at cycle 20 aborts the run without a done pulse
    launch(3'd0);
    collect(100, 1'b0, 20, -1);
    check("abort_no_done", done_cyc.size(), 0);

    // A fresh start after the abort reproduces the flat run
    launch(3'd0);
    collect(70, 1'b0, -1, -1);
    check_flat_run("rerun");

    // start held high, size changed mid-run
    launch(3'd0);
    collect(80, 1'b1, -1, 30);
    check("hold_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("hold_done_cycle", done_cyc[0], 67);
    check("hold_addr_held", addr_log[68], 63);
    check("hold_rerun_tap0", addr_log[69], 0);
    check("hold_rerun_tap1", addr_log[70], 1);
    check("hold_rerun_tap2", addr_log[71], 16);
    check("hold_rerun_tap3", addr_log[72], 17);
    check("hold_first_run_writes", wr_cyc.size() >= 16 ? wr_cyc[15] : -1, 66);
    check("hold_rerun_first_write", wr_cyc.size() >= 17 ? wr_cyc[16] : -1, 74);
    check("hold_rerun_first_addr", wr_addr.size() >= 17 ? wr_addr[16] : -1, 0);
    size_downsample = 3'd0;
    do_reset();

    // Input word equals its address
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i);
    launch(3'd0);
    collect(70, 1'b0, -1, -1);
    check("addr_tap_0", addr_log[1], 0);
    check("addr_tap_1", addr_log[2], 1);
    check("addr_tap_2", addr_log[3], 8);
    check("addr_tap_3", addr_log[4], 9);
    check("addr_tap_4", addr_log[5], 2);
    check("addr_tap_5", addr_log[6], 3);
    check("addr_tap_6", addr_log[7], 10);
    check("addr_tap_7", addr_log[8], 11);
`ifdef DOWNSAMPLE_ROUND_EN
    check("addrdata_pix0", wr_data.size() > 0 ? wr_data[0] : -1, 5);
    check("addrdata_pix1", wr_data.size() > 1 ? wr_data[1] : -1, 7);
`else
    check("addrdata_pix0", wr_data.size() > 0 ? wr_data[0] : -1, 4);
    check("addrdata_pix1", wr_data.size() > 1 ? wr_data[1] : -1, 6);
`endif

    // Vector table: window j of the 8x8 map holds vector j
    for (int j = 0; j < 16; j++) begin
      base = (j / 4) * 16 + (j % 4) * 2;
      mem[base]     = vecs[j].t0;
      mem[base + 1] = vecs[j].t1;
      mem[base + 8] = vecs[j].t2;
      mem[base + 9] = vecs[j].t3;
    end
    launch(3'd0);
    collect(70, 1'b0, -1, -1);
    check("vec_write_count", wr_data.size(), 16);
    for (int j = 0; j < 16 && j < wr_data.size(); j++) begin
`ifdef DOWNSAMPLE_ROUND_EN
      expv = int'(vecs[j].exp_round);
`else
      expv = int'(vecs[j].exp_floor);
`endif
      check($sformatf("vec%0d_data", j), wr_data[j], expv);
    end

    // Largest map, then an out-of-range size that clamps to it
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0100;
    launch(3'd4);
    collect(16400, 1'b0, -1, -1);
    check_max_run("size4");
    launch(3'd7);
    collect(16400, 1'b0, -1, -1);
    check_max_run("size7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/top_downsample.md
# top_downsample

2×2 average-pool downsampler for the RasenGAN feature-map datapath; the inverse of the upsampler. Reads a square W×W signed fixed-point map from an external synchronous-read buffer and writes the (W/2)×(W/2) result to an output buffer. One output pixel is produced every 4 cycles. Start/done control matches the sibling upsample block.

## Interface
- `length`, 16, sample width in bits (signed two's complement fixed point)
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  begin one map; sampled only in IDLE
- `size_downsample`  in  3  input width W = 8<<size (0:8 … 4:128); values 5–7 behave as 4; latched at start
- `done`  out  1  one-cycle pulse after the last write
- `addr_input`  out  14  input read address, row*W+col, registered
- `t_data_in`  in  length  input read data, valid the cycle after `addr_input`
- `t_data_out`  out  length  averaged pixel, registered
- `addr_output`  out  14  output write address, r*(W/2)+c, registered
- `en_write_out`  out  1  output write strobe, one cycle per pixel

## Operation
- Reset (rst=0 at an edge): state IDLE. `done`, `en_write_out`, `addr_input`, `addr_output` and `t_data_out` all 0. Accumulator and counters are cleared. Reset mid-run aborts without a done pulse.
- FSM states:
  - IDLE: on start=1 latch size, go RUN.
  - RUN: issue 4 taps per output pixel, pixels in row-major order. Go DRAIN after the last tap.
  - DRAIN: 2 cycles; go DONE.
  - DONE: pulse done for 1 cycle; go IDLE.
- Tap order for output (r,c): (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
- The accumulator is 18-bit signed and sums the four sign-extended taps. The result is the sum arithmetically shifted right by 2 and truncated to `length` bits. This cannot overflow.
- start while not IDLE is ignored. `size_downsample` changes after start are ignored.
- Output count N = (W/2)². The output address wraps nowhere; the last write goes to N-1.

## Timing
- Cycle 0 is the edge where start=1 is sampled in IDLE.
- For pixel j and tap k: `addr_input` is valid during cycle 4j+k+1, and `t_data_in` is sampled during cycle 4j+k+2.
- The write for pixel j is visible during cycle 4j+6: `en_write_out`=1, with `t_data_out` and `addr_output` valid.
- Back-to-back pixels overlap: tap 3 data of pixel j arrives in the same cycle tap 0 of pixel j+1 is issued. There are no bubbles.
- `done` is high during cycle 4N+3. IDLE is reached at 4N+4, and start is accepted again from that cycle.
- Outside writes `en_write_out`=0. `t_data_out`, `addr_output` and `addr_input` hold their last values.

## Configuration
- `DOWNSAMPLE_ROUND_EN` defined: add 2 to the sum before the shift (round half toward +∞).
- `DOWNSAMPLE_ROUND_EN` undefined: plain arithmetic shift (floor).
- The macro does not change latency or interface.

## Structure
- Package `downsample_pkg` holds:
  - `ADDR_W`=14
  - `ACC_W`=length+2
  - size encoding constants `SIZE_8`…`SIZE_128` and max-size clamp
  - the FSM state typedef (IDLE, RUN, DRAIN, DONE)
- Sub-module `addr_gen_downsample`:
  - contains the tap, column and row counters
  - produces `addr_input`, the output pixel index, and a last-tap flag
- The top holds the FSM, the accumulator/rounding, and the output registers.

## Test plan
- size=0, all input words 0x0100, start at cycle 0:
  - 16 writes of 0x0100 to addr_output 0..15 at cycles 6,10,…,66
  - done at cycle 67
- size=0, input word = its address:
  - pixel 0 reads 0,1,8,9 and the sum is 18
  - t_data_out = 4 without the macro, 5 with it
  - pixel 1 reads 2,3,10,11
- Taps −1,−1,−1,−2 (sum −5):
  - 0xFFFE without the macro, 0xFFFF with it
  - all taps 0x7FFF → 0x7FFF in both builds
- size=4: last input address 16383 and last addr_output 4095, written at cycle 16386; done at 16387. size=7 gives identical results.
- rst=0 at cycle 20 of a run:
  - next cycle all outputs are 0 and no done pulse occurs
  - a new start reproduces scenario 1 exactly
- start held high throughout and `size_downsample` toggled mid-run:
  - exactly one run with the latched size
  - new run begins only from cycle 4N+4
